// File: rtl/uproc_pkg.sv
// Shared decode constants and types for the uProcessor instruction-decode stage.
// Opcode classes are matched with mask/value pairs so one helper covers every class.
package uproc_pkg;

    localparam logic [3:0] OP_LDI = 4'b1000;
    localparam logic [3:0] OP_NOP = 4'b1001;

    localparam logic [3:0] OP_ALU_MASK   = 4'b1000;
    localparam logic [3:0] OP_ALU_VAL    = 4'b0000;
    localparam logic [3:0] OP_CY_MASK    = 4'b1110;
    localparam logic [3:0] OP_CY_VAL     = 4'b0000;
    localparam logic [3:0] OP_STORE_MASK = 4'b1100;
    localparam logic [3:0] OP_STORE_VAL  = 4'b1100;
    localparam logic [3:0] OP_RSVD_MASK  = 4'b1110;
    localparam logic [3:0] OP_RSVD_VAL   = 4'b1010;

    localparam logic [2:0] ALU_NONE = 3'b111;

    typedef enum logic {S_OP, S_IMM} id_state_t;

    typedef struct packed {
        logic [2:0] alu_code;
        logic       reg_ce;
        logic       cy_ce;
        logic       a_ce;
        logic       reset_cy;
        logic       imm_sel;
        logic       illegal;
    } id_ctl_t;

    localparam id_ctl_t CTL_RESET = '{alu_code: ALU_NONE, default: 1'b0};

    function automatic logic op_match(input logic [3:0] op, input logic [3:0] mask,
                                      input logic [3:0] val);
        return (op & mask) == val;
    endfunction

endpackage

// File: rtl/id_pipe_if.sv
// Handshake and decode-bundle bus between fetch, the decode stage and the datapath.
// slave is the decode stage's view; master is the fetch/datapath (or bench) view.
interface id_pipe_if #(
    parameter int NUM_REGS = 4
);
    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int INS_W  = 4 + REG_AW;

    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [INS_W-1:0]    Ins;
    logic                out_valid;
    logic                out_ready;
    logic [NUM_REGS-1:0] RegAddr;
    logic [2:0]          ALUCode;
    logic                Reg_CE;
    logic                CY_CE;
    logic                A_CE;
    logic                ResetCY;
    logic [INS_W-1:0]    Imm;
    logic                imm_sel;
    logic                illegal;

    modport slave (
        input  flush, in_valid, Ins, out_ready,
        output in_ready, out_valid, RegAddr, ALUCode, Reg_CE, CY_CE, A_CE,
               ResetCY, Imm, imm_sel, illegal
    );

    modport master (
        output flush, in_valid, Ins, out_ready,
        input  in_ready, out_valid, RegAddr, ALUCode, Reg_CE, CY_CE, A_CE,
               ResetCY, Imm, imm_sel, illegal
    );
endinterface

// File: rtl/id_field_decode.sv
// Purely combinational opcode -> control-bundle decode plus one-hot register select.
// is_ldi tells the pipeline that an immediate word follows.
module id_field_decode
    import uproc_pkg::*;
#(
    parameter int NUM_REGS = 4,
    localparam int REG_AW = $clog2(NUM_REGS),
    localparam int INS_W  = 4 + REG_AW
) (
    input  logic [INS_W-1:0]    ins,
    output id_ctl_t             ctl,
    output logic [NUM_REGS-1:0] reg_addr,
    output logic                is_ldi
);

    logic [3:0]        op;
    logic [REG_AW-1:0] rnum;

    assign op   = ins[INS_W-1 -: 4];
    assign rnum = ins[REG_AW-1:0];

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_onehot
        assign reg_addr[gi] = (rnum == REG_AW'(gi));
    end

    always_comb begin
        ctl          = CTL_RESET;
        ctl.reset_cy = 1'b1;
        is_ldi       = 1'b0;
        if (op_match(op, OP_ALU_MASK, OP_ALU_VAL)) begin
            ctl.alu_code = op[2:0];
            ctl.a_ce     = 1'b1;
            if (op_match(op, OP_CY_MASK, OP_CY_VAL)) begin
                ctl.cy_ce    = 1'b1;
                ctl.reset_cy = 1'b0;
            end
        end else if (op == OP_LDI) begin
            ctl.a_ce    = 1'b1;
            ctl.imm_sel = 1'b1;
            is_ldi      = 1'b1;
        end else if (op == OP_NOP) begin
            ctl.a_ce = 1'b0;
        end else if (op_match(op, OP_RSVD_MASK, OP_RSVD_VAL)) begin
            ctl.illegal = 1'b1;
        end else if (op_match(op, OP_STORE_MASK, OP_STORE_VAL)) begin
            ctl.reg_ce = 1'b1;
        end
    end

endmodule

// File: rtl/id_pipe.sv
// Registered instruction-decode stage: valid/ready in, one registered bundle out per
// instruction, with two-word LDI sequencing and flush.
module id_pipe
    import uproc_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    id_pipe_if.slave bus
);

    localparam int REG_AW = $clog2(NUM_REGS);
    localparam int INS_W  = 4 + REG_AW;

    id_state_t           state_reg;
    logic                out_valid_reg;
    id_ctl_t             ctl_reg;
    logic [NUM_REGS-1:0] addr_reg;
    logic [INS_W-1:0]    imm_reg;
    id_ctl_t             pend_ctl_reg;
    logic [NUM_REGS-1:0] pend_addr_reg;

    id_ctl_t             dec_ctl;
    logic [NUM_REGS-1:0] dec_addr;
    logic                dec_is_ldi;
    logic                in_ready;
    logic                accept;

    id_field_decode #(.NUM_REGS(NUM_REGS)) u_dec (
        .ins      (bus.Ins),
        .ctl      (dec_ctl),
        .reg_addr (dec_addr),
        .is_ldi   (dec_is_ldi)
    );

    assign in_ready = !bus.flush && (!out_valid_reg || bus.out_ready);
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_OP;
            out_valid_reg <= 1'b0;
            ctl_reg       <= CTL_RESET;
            addr_reg      <= '0;
            imm_reg       <= '0;
            pend_ctl_reg  <= CTL_RESET;
            pend_addr_reg <= '0;
        end else if (bus.flush) begin
            out_valid_reg <= 1'b0;
            state_reg     <= S_OP;
        end else begin
            if (out_valid_reg && bus.out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept) begin
                case (state_reg)
                    S_OP: begin
                        if (dec_is_ldi) begin
                            // Hold the LDI decode until its immediate word arrives.
                            pend_ctl_reg  <= dec_ctl;
                            pend_addr_reg <= dec_addr;
                            state_reg     <= S_IMM;
                        end else begin
                            ctl_reg       <= dec_ctl;
                            addr_reg      <= dec_addr;
                            out_valid_reg <= 1'b1;
                        end
                    end
                    S_IMM: begin
                        ctl_reg       <= pend_ctl_reg;
                        addr_reg      <= pend_addr_reg;
                        imm_reg       <= bus.Ins;
                        out_valid_reg <= 1'b1;
                        state_reg     <= S_OP;
                    end
                    default: state_reg <= S_OP;
                endcase
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_reg;
    assign bus.RegAddr   = addr_reg;
    assign bus.ALUCode   = ctl_reg.alu_code;
    assign bus.Imm       = imm_reg;
    // Enables are qualified so a stale bundle can never write the datapath.
    assign bus.Reg_CE    = ctl_reg.reg_ce   & out_valid_reg;
    assign bus.CY_CE     = ctl_reg.cy_ce    & out_valid_reg;
    assign bus.A_CE      = ctl_reg.a_ce     & out_valid_reg;
    assign bus.ResetCY   = ctl_reg.reset_cy & out_valid_reg;
    assign bus.imm_sel   = ctl_reg.imm_sel  & out_valid_reg;
    assign bus.illegal   = ctl_reg.illegal  & out_valid_reg;

endmodule
